// File: rtl/huff_pkg.sv
// Shared encodings for the Huffman merge/split datapath: phase codes on the
// 3-bit state bus plus width constants used by every block that decodes it.
package huff_pkg;

  localparam int STATE_W      = 3;
  localparam int ADDR_W       = 3;
  localparam int SC_W         = 7;
  localparam int NUM_LEAF_DEF = 6;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE        = 3'd0,
    S_COUNT       = 3'd1,
    S_SORT        = 3'd2,
    S_SORT_DECODE = 3'd3,
    S_MERGE       = 3'd4,
    S_SPLIT       = 3'd5,
    S_DONE        = 3'd6
  } huff_state_e;

endpackage

// File: rtl/huff_seq_ctrl.sv
// Phase sequencer for the Huffman datapath: counts a frame of symbols, runs one
// sort/decode/merge loop per merge level, then the split pass that assigns codes.
module huff_seq_ctrl
  import huff_pkg::*;
#(
  parameter int NUM_SYMS    = 100,
  parameter int NUM_LEAF    = NUM_LEAF_DEF,
  parameter int SORT_CYCLES = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               gray_valid,
  output logic [STATE_W-1:0] state,
  output logic [ADDR_W-1:0]  addr,
  output logic               cnt_en,
  output logic               busy,
  output logic               code_valid
);

  localparam logic [SC_W-1:0]   SC_LAST = SC_W'(NUM_SYMS);
  localparam logic [ADDR_W-1:0] ST_LAST = ADDR_W'(SORT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] MC_LAST = ADDR_W'(NUM_LEAF - 3);

  huff_state_e       state_q, state_d;
  logic [SC_W-1:0]   sc_q, sc_d, sc_inc;
  logic [ADDR_W-1:0] st_q, st_d;
  logic [ADDR_W-1:0] mc_q, mc_d;
  logic [ADDR_W-1:0] addr_d;

  assign sc_inc = sc_q + 1'b1;
  assign state  = state_q;
  assign cnt_en = gray_valid && (state_q == S_IDLE || state_q == S_COUNT);

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    st_d    = st_q;
    mc_d    = mc_q;
    case (state_q)
      S_IDLE: begin
        if (gray_valid) begin
          state_d = S_COUNT;
          sc_d    = SC_W'(1);
        end
      end
      S_COUNT: begin
        if (gray_valid) begin
          sc_d = sc_inc;
          if (sc_inc == SC_LAST) begin
            state_d = S_SORT;
            st_d    = '0;
            mc_d    = '0;
          end
        end
      end
      S_SORT: begin
        if (st_q == ST_LAST) state_d = S_SORT_DECODE;
        else                 st_d    = st_q + 1'b1;
      end
      S_SORT_DECODE: state_d = S_MERGE;
      S_MERGE: begin
        if (mc_q < MC_LAST) begin
          mc_d    = mc_q + 1'b1;
          st_d    = '0;
          state_d = S_SORT;
        end else begin
          state_d = S_SPLIT;
        end
      end
      S_SPLIT: begin
        if (mc_q == '0) state_d = S_DONE;
        else            mc_d    = mc_q - 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        sc_d    = '0;
      end
      default: begin
        // unused encoding 7 falls back to a clean idle
        state_d = S_IDLE;
        sc_d    = '0;
        st_d    = '0;
        mc_d    = '0;
      end
    endcase
  end

  // addr is registered, so derive it from the next-state view of the counters
  always_comb begin
    addr_d = '0;
    case (state_d)
      S_SORT:                           addr_d = st_d;
      S_SORT_DECODE, S_MERGE, S_SPLIT:  addr_d = mc_d;
      default:                          addr_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sc_q       <= '0;
      st_q       <= '0;
      mc_q       <= '0;
      addr       <= '0;
      busy       <= 1'b0;
      code_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      sc_q       <= sc_d;
      st_q       <= st_d;
      mc_q       <= mc_d;
      addr       <= addr_d;
      busy       <= (state_d != S_IDLE);
      code_valid <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_huff_seq_ctrl.sv
// Randomized bench for huff_seq_ctrl: two configurations checked every cycle
// against a frame-position model of the expected phase/addr trace.
module tb_huff_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       gray_valid;
  logic [2:0] state0, addr0, state1, addr1;
  logic       cnt_en0, busy0, cv0, cnt_en1, busy1, cv1;

  always #5 clk = ~clk;

  huff_seq_ctrl dut0 (
    .clk(clk), .reset(reset), .gray_valid(gray_valid),
    .state(state0), .addr(addr0), .cnt_en(cnt_en0), .busy(busy0), .code_valid(cv0)
  );

  huff_seq_ctrl #(.NUM_SYMS(5), .NUM_LEAF(3), .SORT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .gray_valid(gray_valid),
    .state(state1), .addr(addr1), .cnt_en(cnt_en1), .busy(busy1), .code_valid(cv1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // model: mode 0 idle, 1 counting, 2 walking the post-count trace by position
  int p_n[2]  = '{100, 5};
  int p_sc[2] = '{5, 1};
  int p_l[2]  = '{6, 3};
  int mmode[2], mcnt[2], mpos[2];
  int cyc = 0, en_cnt = 0, first_sort = -1, first_cv = -1;

  function automatic int merge_len(input int i);
    return (p_l[i] - 2) * (p_sc[i] + 2);
  endfunction

  function automatic void exp_out(input int i, output int s, output int a);
    int p, r, per;
    s = 0; a = 0;
    if (mmode[i] == 1) s = 1;
    else if (mmode[i] == 2) begin
      p = mpos[i];
      per = p_sc[i] + 2;
      if (p < merge_len(i)) begin
        r = p % per;
        if (r < p_sc[i])       begin s = 2; a = r;       end
        else if (r == p_sc[i]) begin s = 3; a = p / per; end
        else                   begin s = 4; a = p / per; end
      end else if (p < merge_len(i) + p_l[i] - 2) begin
        s = 5; a = p_l[i] - 3 - (p - merge_len(i));
      end else s = 6;
    end
  endfunction

  task automatic model_step(input int i, input bit gv);
    case (mmode[i])
      0: if (gv) begin mmode[i] = 1; mcnt[i] = 1; end
      1: if (gv) begin
           mcnt[i]++;
           if (mcnt[i] == p_n[i]) begin mmode[i] = 2; mpos[i] = 0; end
         end
      default: if (mpos[i] == merge_len(i) + p_l[i] - 2) begin
                 mmode[i] = 0; mcnt[i] = 0;
               end else mpos[i]++;
    endcase
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin mmode[i] = 0; mcnt[i] = 0; mpos[i] = 0; end
  endtask

  task automatic check_outs();
    int s, a;
    exp_out(0, s, a);
    chk("state0", state0, s); chk("addr0", addr0, a);
    chk("busy0", busy0, s != 0); chk("cv0", cv0, s == 6);
    exp_out(1, s, a);
    chk("state1", state1, s); chk("addr1", addr1, a);
    chk("busy1", busy1, s != 0); chk("cv1", cv1, s == 6);
    if (state0 == 3'd2 && first_sort < 0) first_sort = cyc;
    if (cv0 && first_cv < 0) first_cv = cyc;
  endtask

  // called at a falling edge: drive, check cnt_en, clock, check registered outputs
  task automatic cycle(input bit gv);
    gray_valid = gv;
    #1;
    chk("cnt_en0", cnt_en0, gv && mmode[0] <= 1);
    chk("cnt_en1", cnt_en1, gv && mmode[1] <= 1);
    if (cnt_en0) en_cnt++;
    @(posedge clk);
    model_step(0, gv);
    model_step(1, gv);
    cyc++;
    @(negedge clk);
    check_outs();
  endtask

  initial begin
    bit reached;
    reset = 1'b1;
    gray_valid = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_outs();
    reset = 1'b0;

    // dense frame: exactly 100 enables, first SORT to code_valid timing
    for (int k = 0; k < 100; k++) cycle(1'b1);
    for (int k = 0; k < 40; k++)  cycle(1'b0);
    chk("cnt_en_count", en_cnt, 100);
    chk("sort_to_cv", first_cv - first_sort, 32);

    // sparse frame plus idle gaps
    for (int k = 0; k < 250; k++) cycle($urandom_range(0, 99) < 40);
    for (int k = 0; k < 40; k++)  cycle(1'b0);

    // valid held high through processing and the restart after DONE
    for (int k = 0; k < 150; k++) cycle(1'b1);
    for (int k = 0; k < 60; k++)  cycle(1'b0);

    // asynchronous reset during the third merge level
    for (int k = 0; k < 100; k++) cycle(1'b1);
    reached = 1'b0;
    for (int k = 0; k < 40 && !reached; k++) begin
      if (mmode[0] == 2 && mpos[0] == 2 * 7 + 2) reached = 1'b1;
      else cycle(1'b0);
    end
    chk("reach_level3", reached, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_state", state0, 0); chk("rst_addr", addr0, 0);
    chk("rst_busy", busy0, 0);   chk("rst_cv", cv0, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_outs();
    for (int k = 0; k < 100; k++) cycle(1'b1);
    for (int k = 0; k < 40; k++)  cycle($urandom_range(0, 1) == 1);
    for (int k = 0; k < 40; k++)  cycle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
